// File: rtl/rom_upload_pkg.sv
// rom_upload_pkg: shared definitions for the boot ROM upload/download paths.
//   state_t    - upload sequencer states
//   PG_*       - SDRAM page bases of the four ROM slots
//   map_t      - result of a host-address translation {valid, bank, addr}
//   map_addr() - host linear byte address -> SDRAM page map
package rom_upload_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_FETCH,
        S_WAIT_ACK,
        S_HOLD,
        S_DONE
    } state_t;

    localparam logic [8:0] PG_OS     = 9'h000;
    localparam logic [8:0] PG_BASIC  = 9'h100;
    localparam logic [8:0] PG_AMSDOS = 9'h107;
    localparam logic [8:0] PG_MF2    = 9'h1FF;

    typedef struct packed {
        logic        valid;
        logic        bank;
        logic [22:0] addr;
    } map_t;

    // Host pages 0..3 land in bank 0, pages 4..7 reuse the same page
    // bases in bank 1. Anything from page 8 upward has no backing store.
    function automatic map_t map_addr(input logic [24:0] addr);
        map_t        m;
        logic [10:0] page;
        logic [8:0]  base;
        page = addr[24:14];
        case (page[1:0])
            2'd0:    base = PG_OS;
            2'd1:    base = PG_BASIC;
            2'd2:    base = PG_AMSDOS;
            default: base = PG_MF2;
        endcase
        m.valid = (page[10:3] == 8'd0);
        m.bank  = page[2];
        m.addr  = {base, addr[13:0]};
        return m;
    endfunction

endpackage

// File: rtl/rom_upload.sv
// rom_upload: streams SDRAM-resident ROM/MF2 images back to the host over
// the ioctl upload channel, keeping one byte prefetched ahead of the host.
// Ports:
//   clk_sys, reset          - system clock, synchronous active-high reset
//   ioctl_ce                - qualifies every host-side strobe/edge
//   ioctl_upload/index      - session active / target selector
//   ioctl_rd, ioctl_addr    - host byte request and its address
//   ioctl_din, ioctl_wait   - returned byte, host hold-off
//   mem_rd/addr/bank        - SDRAM read request (held until mem_ack)
//   mem_ack, mem_dout       - SDRAM one-cycle ack with data
//   checksum, err, busy     - session byte sum, sticky timeout, active
module rom_upload
    import rom_upload_pkg::*;
#(
    parameter int         TIMEOUT  = 64,
    parameter logic [7:0] UP_INDEX = 8'h00
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        ioctl_ce,
    input  logic        ioctl_upload,
    input  logic [7:0]  ioctl_index,
    input  logic        ioctl_rd,
    input  logic [24:0] ioctl_addr,
    output logic [7:0]  ioctl_din,
    output logic        ioctl_wait,
    output logic        mem_rd,
    output logic [22:0] mem_addr,
    output logic        mem_bank,
    input  logic        mem_ack,
    input  logic [7:0]  mem_dout,
    output logic [7:0]  checksum,
    output logic        err,
    output logic        busy
);

    localparam int              CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

    state_t           state, state_nxt;
    logic             upload_q;
    logic [24:0]      next_addr;
    logic [7:0]       prefetch;
    logic             pf_valid;
    logic             pending;     // seek accepted, byte owed to the host
    logic [CNT_W-1:0] tmo_cnt;
    map_t             map;

    logic rd_stb, up_rise, up_fall;
    logic start, issue, unmapped, got_ack, tmo, deliver, seek;

    assign rd_stb  = ioctl_ce & ioctl_rd;
    assign up_rise = ioctl_ce & ioctl_upload & ~upload_q;
    assign up_fall = ioctl_ce & ~ioctl_upload;
    assign map     = map_addr(next_addr);

    assign mem_rd     = (state == S_WAIT_ACK);
    assign busy       = (state != S_IDLE);
    assign ioctl_wait = (state == S_ARM) | (state == S_FETCH) |
                        (state == S_WAIT_ACK) | pending;

    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        issue     = 1'b0;
        unmapped  = 1'b0;
        got_ack   = 1'b0;
        tmo       = 1'b0;
        deliver   = 1'b0;
        seek      = 1'b0;
        // Session end wins over everything, including an ack this cycle.
        if (up_fall && state != S_IDLE && state != S_DONE) begin
            state_nxt = S_DONE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (up_rise && ioctl_index == UP_INDEX) begin
                        start     = 1'b1;
                        state_nxt = S_ARM;
                    end
                end
                S_ARM: state_nxt = S_FETCH;
                S_FETCH: begin
                    if (map.valid) begin
                        issue     = 1'b1;
                        state_nxt = S_WAIT_ACK;
                    end else begin
                        unmapped  = 1'b1;
                        state_nxt = S_HOLD;
                    end
                end
                S_WAIT_ACK: begin
                    if (mem_ack) begin
                        got_ack   = 1'b1;
                        state_nxt = S_HOLD;
                    end else if (tmo_cnt == TMO_LAST) begin
                        tmo       = 1'b1;
                        state_nxt = S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (pf_valid) begin
                        if (pending) begin
                            deliver   = 1'b1;
                            state_nxt = S_FETCH;
                        end else if (rd_stb) begin
                            if (ioctl_addr == next_addr) deliver = 1'b1;
                            else                         seek    = 1'b1;
                            state_nxt = S_FETCH;
                        end
                    end
                end
                S_DONE:  state_nxt = S_IDLE;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state     <= S_IDLE;
            upload_q  <= 1'b0;
            ioctl_din <= 8'hFF;
            checksum  <= 8'h00;
            err       <= 1'b0;
            next_addr <= '0;
            prefetch  <= 8'hFF;
            pf_valid  <= 1'b0;
            pending   <= 1'b0;
            tmo_cnt   <= '0;
            mem_addr  <= '0;
            mem_bank  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (ioctl_ce) upload_q <= ioctl_upload;

            if (start) begin
                checksum  <= 8'h00;
                err       <= 1'b0;
                tmo_cnt   <= '0;
                next_addr <= '0;
                pending   <= 1'b0;
                pf_valid  <= 1'b0;
            end
            if (issue) begin
                mem_addr <= map.addr;
                mem_bank <= map.bank;
                tmo_cnt  <= '0;
            end
            if (state == S_WAIT_ACK && state_nxt == S_WAIT_ACK)
                tmo_cnt <= tmo_cnt + 1'b1;
            if (unmapped) begin
                prefetch <= 8'hFF;
                pf_valid <= 1'b1;
            end
            if (got_ack) begin
                prefetch <= mem_dout;
                pf_valid <= 1'b1;
            end
            if (tmo) begin
                prefetch <= 8'hFF;
                err      <= 1'b1;
                pf_valid <= 1'b1;
            end
            if (deliver) begin
                ioctl_din <= prefetch;
                checksum  <= checksum + prefetch;
                next_addr <= next_addr + 25'd1;  // wraps to 0 by design
                pending   <= 1'b0;
                pf_valid  <= 1'b0;
            end
            if (seek) begin
                next_addr <= ioctl_addr;
                pending   <= 1'b1;
                pf_valid  <= 1'b0;
            end
            if (state_nxt == S_DONE) begin
                pending  <= 1'b0;
                pf_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rom_upload.sv
module tb_rom_upload;

    logic        clk_sys = 1'b0;
    logic        reset, ioctl_ce, ioctl_upload, ioctl_rd;
    logic [7:0]  ioctl_index;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_din, checksum, mem_dout;
    logic        ioctl_wait, mem_rd, mem_bank, mem_ack, err, busy;
    logic [22:0] mem_addr;

    logic model_en   = 1'b1;
    logic manual_ack = 1'b0;
    int   mcnt       = 0;
    int   checks     = 0;
    int   errors     = 0;

    always #5 clk_sys = ~clk_sys;

    rom_upload #(.TIMEOUT(64), .UP_INDEX(8'h00)) dut (
        .clk_sys(clk_sys), .reset(reset), .ioctl_ce(ioctl_ce),
        .ioctl_upload(ioctl_upload), .ioctl_index(ioctl_index),
        .ioctl_rd(ioctl_rd), .ioctl_addr(ioctl_addr), .ioctl_din(ioctl_din),
        .ioctl_wait(ioctl_wait), .mem_rd(mem_rd), .mem_addr(mem_addr),
        .mem_bank(mem_bank), .mem_ack(mem_ack), .mem_dout(mem_dout),
        .checksum(checksum), .err(err), .busy(busy)
    );

    // SDRAM contents: two preloaded bytes, otherwise a fixed pattern.
    function automatic logic [7:0] mem_val(input logic bank, input logic [22:0] a);
        if (!bank && a == 23'd0) return 8'h01;
        if (!bank && a == 23'd1) return 8'h02;
        return a[7:0] ^ 8'h5A ^ {bank, 7'b0};
    endfunction

    // SDRAM responder: acks on the 3rd cycle of a held request.
    initial begin
        mem_ack  = 1'b0;
        mem_dout = 8'h00;
        forever begin
            @(posedge clk_sys); #2;
            mem_ack = manual_ack;
            if (mem_rd && model_en) begin
                mcnt++;
                if (mcnt == 3) begin
                    mem_ack  = 1'b1;
                    mem_dout = mem_val(mem_bank, mem_addr);
                    mcnt     = 0;
                end
            end else begin
                mcnt = 0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys); #1;
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (ioctl_wait !== 1'b0 && n < 500) begin tick(); n++; end
        chk({tag, " ready"}, 32'(ioctl_wait), 0);
    endtask

    task automatic wait_memrd(input string tag);
        int n = 0;
        while (mem_rd !== 1'b1 && n < 50) begin tick(); n++; end
        chk({tag, " mem_rd"}, 32'(mem_rd), 1);
    endtask

    // Sequential host read: byte comes back the cycle after ioctl_rd.
    task automatic rd_seq(input logic [24:0] a, input logic [7:0] exp);
        wait_ready("seq");
        ioctl_addr = a; ioctl_rd = 1'b1;
        tick();
        ioctl_rd = 1'b0;
        chk("seq din", 32'(ioctl_din), 32'(exp));
    endtask

    task automatic rd_seek(input logic [24:0] a);
        wait_ready("seek");
        ioctl_addr = a; ioctl_rd = 1'b1;
        tick();
        ioctl_rd = 1'b0;
        chk("seek wait", 32'(ioctl_wait), 1);
    endtask

    initial begin
        int n, cnt;
        logic saw;
        reset = 1'b1; ioctl_ce = 1'b1; ioctl_upload = 1'b0; ioctl_index = 8'h00;
        ioctl_rd = 1'b0; ioctl_addr = '0;
        repeat (3) tick();
        chk("rst din",   32'(ioctl_din), 'hFF);
        chk("rst wait",  32'(ioctl_wait), 0);
        chk("rst mem_rd", 32'(mem_rd), 0);
        chk("rst maddr", 32'(mem_addr), 0);
        chk("rst bank",  32'(mem_bank), 0);
        chk("rst csum",  32'(checksum), 0);
        chk("rst err",   32'(err), 0);
        chk("rst busy",  32'(busy), 0);
        reset = 1'b0;
        tick();

        // Session 1: sequential bytes 0..3
        ioctl_upload = 1'b1;
        tick();
        chk("arm busy", 32'(busy), 1);
        chk("arm wait", 32'(ioctl_wait), 1);
        rd_seq(25'd0, 8'h01);
        rd_seq(25'd1, 8'h02);
        chk("csum 0..1", 32'(checksum), 'h03);
        chk("err 0..1",  32'(err), 0);

        // ioctl_rd without ioctl_ce must be ignored
        wait_ready("ce");
        ioctl_ce = 1'b0; ioctl_addr = 25'd2; ioctl_rd = 1'b1;
        tick();
        ioctl_rd = 1'b0; ioctl_ce = 1'b1;
        chk("ce din",  32'(ioctl_din), 'h02);
        chk("ce csum", 32'(checksum), 'h03);

        rd_seq(25'd2, 8'h58);
        rd_seq(25'd3, 8'h59);
        chk("csum 0..3", 32'(checksum), 'hB4);

        // Seek: byte delivered without a second ioctl_rd
        rd_seek(25'h003FF0);
        wait_ready("seek3ff0");
        chk("seek din",  32'(ioctl_din), 'hAA);
        chk("seek csum", 32'(checksum), 'h5E);

        // Address map
        rd_seek(25'h004000);
        wait_memrd("pg1");
        chk("pg1 addr", 32'(mem_addr), 'h400000);
        chk("pg1 bank", 32'(mem_bank), 0);
        wait_ready("pg1");
        chk("pg1 din", 32'(ioctl_din), 'h5A);

        rd_seek(25'h010000);
        wait_memrd("pg4");
        chk("pg4 addr", 32'(mem_addr), 'h000000);
        chk("pg4 bank", 32'(mem_bank), 1);
        wait_ready("pg4");
        chk("pg4 din", 32'(ioctl_din), 'hDA);

        rd_seek(25'h00C005);
        wait_memrd("pg3");
        chk("pg3 addr", 32'(mem_addr), 'h7FC005);
        chk("pg3 bank", 32'(mem_bank), 0);
        wait_ready("pg3");
        chk("pg3 din", 32'(ioctl_din), 'h5F);

        // Unmapped page 8: FF, no memory access, no error
        rd_seek(25'h020000);
        saw = 1'b0; n = 0;
        while (ioctl_wait !== 1'b0 && n < 200) begin
            if (mem_rd) saw = 1'b1;
            tick(); n++;
        end
        chk("pg8 ready",  32'(ioctl_wait), 0);
        chk("pg8 mem_rd", 32'(saw), 0);
        chk("pg8 din",    32'(ioctl_din), 'hFF);
        chk("pg8 err",    32'(err), 0);
        chk("pg8 csum",   32'(checksum), 'hF0);

        // Timeout: memory never acks
        model_en = 1'b0;
        rd_seek(25'h000100);
        n = 0;
        while (mem_rd !== 1'b1 && n < 20) begin tick(); n++; end
        cnt = 0;
        while (mem_rd === 1'b1 && cnt < 200) begin cnt++; tick(); end
        chk("tmo cycles", 32'(cnt), 64);
        tick();
        chk("tmo din",  32'(ioctl_din), 'hFF);
        chk("tmo err",  32'(err), 1);
        chk("tmo csum", 32'(checksum), 'hEF);

        // Drop upload while a read is outstanding, then a late ack
        tick();
        chk("drop pre mem_rd", 32'(mem_rd), 1);
        ioctl_upload = 1'b0;
        tick();
        chk("drop mem_rd", 32'(mem_rd), 0);
        manual_ack = 1'b1;
        tick();
        manual_ack = 1'b0;
        chk("drop busy",   32'(busy), 0);
        chk("drop mem_rd2", 32'(mem_rd), 0);
        chk("drop err",    32'(err), 1);
        chk("drop csum",   32'(checksum), 'hEF);

        // Foreign index does not start a session
        ioctl_index = 8'h01; ioctl_upload = 1'b1;
        tick(); tick();
        chk("idx busy", 32'(busy), 0);
        ioctl_upload = 1'b0; ioctl_index = 8'h00;
        tick(); tick();

        // Session 2: start clears, then reset mid-transfer
        model_en = 1'b1; ioctl_upload = 1'b1;
        tick();
        chk("s2 csum clr", 32'(checksum), 0);
        chk("s2 err clr",  32'(err), 0);
        rd_seq(25'd0, 8'h01);
        chk("s2 csum", 32'(checksum), 'h01);
        wait_memrd("s2 pf");
        chk("s2 pf addr", 32'(mem_addr), 'h000001);
        reset = 1'b1;
        tick();
        chk("mid rst mem_rd", 32'(mem_rd), 0);
        chk("mid rst busy",   32'(busy), 0);
        chk("mid rst wait",   32'(ioctl_wait), 0);
        chk("mid rst din",    32'(ioctl_din), 'hFF);
        chk("mid rst csum",   32'(checksum), 0);
        chk("mid rst maddr",  32'(mem_addr), 0);
        reset = 1'b0; ioctl_upload = 1'b0;
        tick();
        chk("post rst busy", 32'(busy), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rom_upload.md
Name: rom_upload

Overview:
- Reverse path of the boot ROM loader: streams SDRAM-resident ROM/MF2 images back to the host over the mist_io ioctl upload channel.
- Translates the host linear byte address to the same SDRAM page map the download path uses.
- Issues single-byte SDRAM reads through a request/acknowledge port, prefetching one byte ahead.
- Sits between mist_io (upload side) and the sdram arbiter; active only while ioctl_upload is high.

Parameters:
- TIMEOUT, 64: clk_sys cycles to wait for mem_ack before substituting 8'hFF and flagging error.
- UP_INDEX, 8'h00: ioctl_index value that selects ROM upload; any other index is ignored.

Ports:
- clk_sys  in  1  system clock
- reset  in  1  synchronous, active-high
- ioctl_ce  in  1  ioctl clock enable; all host-side strobes are sampled only when high
- ioctl_upload  in  1  host upload session active
- ioctl_index  in  8  upload target selector
- ioctl_rd  in  1  host byte request, one ioctl_ce-qualified pulse per byte
- ioctl_addr  in  25  host byte address of the current request
- ioctl_din  out  8  byte returned to host
- ioctl_wait  out  1  host must hold off further ioctl_rd while high
- mem_rd  out  1  SDRAM read request, held until mem_ack
- mem_addr  out  23  SDRAM byte address
- mem_bank  out  1  SDRAM bank
- mem_ack  in  1  one-cycle pulse; mem_dout valid in the same cycle
- mem_dout  in  8  SDRAM read data
- checksum  out  8  mod-256 sum of all bytes delivered this session
- err  out  1  sticky; set on any timeout during the session
- busy  out  1  session active (state not IDLE)

Behaviour:
- Reset: all outputs 0, ioctl_din = 8'hFF, state IDLE, prefetch register invalid.
- Address map (function map_addr):
  - page = addr[24:14]
  - page 0/4 -> 9'h000; 1/5 -> 9'h100; 2/6 -> 9'h107; 3/7 -> 9'h1FF
  - bank = 1 for pages 4..7, else 0
  - mem_addr = {page_base, addr[13:0]}
  - pages >= 8 are unmapped.
- States: IDLE, ARM, FETCH, WAIT_ACK, HOLD, DONE.
- IDLE: on rising ioctl_upload with ioctl_index == UP_INDEX -> ARM; checksum, err and timeout counter cleared; next_addr = 0.
- ARM: go to FETCH for next_addr; ioctl_wait = 1.
- FETCH:
  - Mapped address: assert mem_rd with mapped address -> WAIT_ACK, counter = 0.
  - Unmapped address: load prefetch = 8'hFF with no memory access -> HOLD.
- WAIT_ACK:
  - mem_rd and mem_addr held stable.
  - On mem_ack: prefetch <= mem_dout, drop mem_rd in the same cycle -> HOLD.
  - If counter reaches TIMEOUT-1 first: prefetch <= 8'hFF, err <= 1, drop mem_rd -> HOLD.
- HOLD: ioctl_wait = 0, prefetch valid; wait for an ioctl_ce-qualified ioctl_rd.
  - ioctl_addr == next_addr: ioctl_din <= prefetch, checksum += prefetch, next_addr + 1 -> FETCH (prefetch next byte).
  - ioctl_addr != next_addr (host seek): next_addr <= ioctl_addr, ioctl_wait = 1 -> FETCH. The requested byte is delivered on the next HOLD without a second ioctl_rd (pending flag), and the checksum counts it then.
- ioctl_wait is 1 in ARM, FETCH and WAIT_ACK, and whenever a pending seek exists.
- Latency: a sequential read is served from prefetch on the cycle after ioctl_rd, giving zero wait states when the host spacing exceeds the SDRAM latency.
- next_addr wraps from 25'h1FFFFFF to 0; this is not an error.
- Falling ioctl_upload in any state -> DONE: drop mem_rd immediately, ignore a late mem_ack. checksum and err keep their values until the next session start. DONE -> IDLE next cycle.
- Reset mid-transfer: immediate return to IDLE and mem_rd = 0, regardless of an outstanding request.
- ioctl_rd arriving while ioctl_wait = 1 is a host protocol violation: it is ignored, and the bench flags it.
- ioctl_rd, ioctl_addr and ioctl_upload edges are observed only on cycles where ioctl_ce = 1. mem_ack is observed every cycle.

Decomposition:
- Package rom_upload_pkg:
  - state enum
  - page base constants PG_OS = 9'h000, PG_BASIC = 9'h100, PG_AMSDOS = 9'h107, PG_MF2 = 9'h1FF
  - function map_addr(addr) returning {valid, bank, mem_addr}; the download path reuses it.
- No sub-module needed; the timeout counter is inline.

Test Plan:
- Preload SDRAM model 0x000000 = 8'h01, 0x000001 = 8'h02; upload bytes 0..1 -> ioctl_din 01 then 02, checksum = 03, err = 0.
- Read ioctl_addr 25'h004000 -> mem_addr = 23'h400000, mem_bank = 0; read 25'h010000 -> mem_addr 23'h000000, mem_bank = 1; read 25'h00C005 -> mem_addr 23'h7FC005.
- Read ioctl_addr 25'h020000 (page 8) -> ioctl_din = FF, mem_rd never asserted, err stays 0.
- Memory model never acks -> mem_rd held exactly TIMEOUT = 64 cycles, ioctl_din = FF, err = 1.
- Sequential bytes 0..3, then seek to 0x3FF0 -> ioctl_wait rises, the byte at 0x3FF0 is delivered without a second ioctl_rd, checksum includes it.
- Drop ioctl_upload during WAIT_ACK, then pulse mem_ack -> mem_rd = 0 next cycle, ack ignored, busy = 0 within 2 cycles; assert reset mid-session -> all outputs at reset values.
